bus_port_fifo: RTL and testbench
================================

# bus_port_fifo

Per-device transmit FIFO between one agent driver and one port of the `bs_gnrtr_n_rbtr` bus. The driver writes packets in. The bus sees the `pndng`/`D_pop` pair for that port and removes packets with `pop`. The FIFO is first-word-fall-through, so the head packet is always present on `D_pop` while `pndng` is high. One instance is built per bus port.

## Interface
- `pckg_sz`, 16: packet width in bits; must equal the bus `pckg_sz`.
- `depth`, 8: number of entries; a power of two, at least 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous reset, active-high.
- `wr_en`  in  1  driver write strobe; a 1-cycle pulse per packet.
- `wr_data`  in  `pckg_sz`  packet written when `wr_en`=1.
- `pop`  in  1  bus removes the head packet this cycle.
- `pndng`  out  1  FIFO non-empty (head valid); reset value 0.
- `D_pop`  out  `pckg_sz`  head packet; forced to 0 when empty; reset value 0.
- `full`  out  1  `count`==`depth`; reset value 0.
- `count`  out  $clog2(depth)+1  occupancy; reset value 0.
- `overflow`  out  1  sticky: a write was dropped; reset value 0.
- `underflow`  out  1  sticky: `pop` arrived while empty; reset value 0.

## Operation
- Storage is a circular array with `wr_ptr`/`rd_ptr` of $clog2(depth) bits. Pointers wrap modulo `depth` naturally. `count` is a separate register.
- Write accepted when `wr_en` && (!`full` || `pop`). Data goes to `mem[wr_ptr]`, then `wr_ptr`++.
- Pop accepted when `pop` && `pndng`. Then `rd_ptr`++.
- `count` update:
  - write only: +1.
  - pop only: −1.
  - both accepted: unchanged.
- Full with `wr_en` and `pop` in the same cycle: both are accepted, and `count` stays at `depth`.
- Full with `wr_en` and no `pop`: the write is dropped, the contents are unchanged, and `overflow` is set.
- Empty with `pop`: the pop is ignored and `underflow` is set.
- Empty with `pop` and `wr_en` in the same cycle: the write is accepted, the pop is ignored, `underflow` is set, and `count` becomes 1.
- `overflow` and `underflow` clear only on `reset`.
- `pndng` = (`count` != 0). `D_pop` = `pndng` ? `mem[rd_ptr]` : 0, combinational from registers.
- Packet order is strictly FIFO; there is no reordering or duplication.

## Timing
- A write at edge N makes `pndng`=1 and `D_pop`=data visible after edge N, which is a 1-cycle write-to-visible latency.
- A pop at edge M makes the next head, or `pndng`=0, visible after edge M. The bus may pop on consecutive cycles and sustain 1 packet/cycle.
- `reset` sampled high at an edge clears pointers, `count` and flags after that edge. Any `wr_en`/`pop` in the same cycle is ignored. Stored contents are discarded and `mem` is not cleared.
- Reset mid-burst: the first accepted write after release lands at entry 0 and appears on `D_pop` one cycle later.
- No combinational path from `pop` or `wr_en` to any output.

## Configuration
- `BUS_FIFO_DROP_CNT_EN` defined: adds output `drop_cnt`, 16 bits.
  - Reset value 0.
  - Increments by 1 for each dropped write.
  - Saturates at 16'hFFFF.
- Not defined: the `drop_cnt` port and its logic are absent. Only the sticky `overflow` flag reports drops.

## Structure
- Shared package `bus_pkg`:
  - default packet width constant `PCKG_SZ` = 16.
  - typedef `pckg_t` (logic [PCKG_SZ-1:0]).
  - function `clog2_depth` used for pointer and count widths.
- One sub-module, `bus_fifo_mem`: a `depth`×`pckg_sz` register array with one synchronous write port and one asynchronous read port (`rd_addr` → `rd_data`). Pointer, count and flag control stay in `bus_port_fifo`.

## Test plan
- Reset, then write 16'hA001, 16'hA002, 16'hA003 on consecutive cycles.
  - `count`=3, `pndng`=1, `D_pop`=16'hA001.
  - Three pops then return A001, A002, A003 in order, after which `pndng`=0 and `D_pop`=0.
- Fill all 8 entries with 16'h0000..16'h0007, then write 16'hDEAD with no pop.
  - `full`=1, `count`=8, `overflow`=1.
  - `drop_cnt`=1 if `BUS_FIFO_DROP_CNT_EN` is defined.
  - Draining yields 0..7, and DEAD never appears.
- While full, assert `wr_en` (16'hBEEF) and `pop` in the same cycle.
  - `count` stays 8, the head advances to 16'h0001, and BEEF comes out last.
- While empty, assert `pop` and `wr_en` (16'h1234) together.
  - `underflow`=1, `count`=1, `D_pop`=16'h1234 in the next cycle.
- Write 20 packets while popping every cycle after the first write.
  - Pointers wrap twice and `count` never exceeds 1.
  - The output sequence equals the input sequence.
- Load 5 packets, then assert `reset` together with `wr_en` (16'h5555).
  - Next cycle: `count`=0, `pndng`=0, `D_pop`=0, flags 0, and 16'h5555 is not stored.
  - A subsequent write of 16'h7777 is the next head.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the bus port transmit FIFO: default packet width,
// packet type and the pointer-width helper.
package bus_pkg;

  localparam int PCKG_SZ = 16;

  typedef logic [PCKG_SZ-1:0] pckg_t;

  // Smallest r with 2**r >= d; sizes FIFO pointers (count gets one bit more).
  function automatic int clog2_depth(input int d);
    int r;
    r = 0;
    while ((1 << r) < d) r++;
    return r;
  endfunction

endpackage

// File: rtl/bus_fifo_mem.sv
// Register array for bus_port_fifo: one synchronous write port and one
// asynchronous read port; contents are never reset.
module bus_fifo_mem
  import bus_pkg::*;
#(
  parameter int pckg_sz = PCKG_SZ,
  parameter int depth   = 8
) (
  input  logic                          clk,
  input  logic                          wr_en,
  input  logic [clog2_depth(depth)-1:0] wr_addr,
  input  logic [pckg_sz-1:0]            wr_data,
  input  logic [clog2_depth(depth)-1:0] rd_addr,
  output logic [pckg_sz-1:0]            rd_data
);

  logic [pckg_sz-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/bus_port_fifo.sv
// First-word-fall-through transmit FIFO feeding one bus port; head packet on D_pop while pndng.
// Latency: write at edge N is visible after N; pop at M shows the next head after M.
// Backpressure: writes dropped when full without pop (sticky overflow; drop_cnt with BUS_FIFO_DROP_CNT_EN).
module bus_port_fifo
  import bus_pkg::*;
#(
  parameter int pckg_sz = PCKG_SZ,
  parameter int depth   = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [pckg_sz-1:0]          wr_data,
  input  logic                        pop,
  output logic                        pndng,
  output logic [pckg_sz-1:0]          D_pop,
  output logic                        full,
  output logic [clog2_depth(depth):0] count,
  output logic                        overflow,
  output logic                        underflow
`ifdef BUS_FIFO_DROP_CNT_EN
  ,
  output logic [15:0]                 drop_cnt
`endif
);

  localparam int AW = clog2_depth(depth);
  localparam int CW = AW + 1;

  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [pckg_sz-1:0] rd_data;
  logic               wr_acc;
  logic               pop_acc;
  logic               wr_drop;

  // A pop on a full FIFO frees the head slot in the same cycle, so the write may reuse it.
  assign wr_acc  = !reset && wr_en && (!full || pop);
  assign pop_acc = !reset && pop && pndng;
  assign wr_drop = wr_en && full && !pop;

  bus_fifo_mem #(
    .pckg_sz (pckg_sz),
    .depth   (depth)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc)  wr_ptr <= wr_ptr + AW'(1);
      if (pop_acc) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_acc, pop_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (wr_drop)       overflow  <= 1'b1;
      if (pop && !pndng) underflow <= 1'b1;
    end
  end

`ifdef BUS_FIFO_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (wr_drop && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

  assign full  = (count == CW'(depth));
  assign pndng = (count != '0);
  assign D_pop = pndng ? rd_data : '0;

endmodule

// File: tb/tb_bus_port_fifo.sv
// Bench for bus_port_fifo: directed vector table, corner-case sequences and
// randomized traffic against a queue-based model.
module tb_bus_port_fifo;

  localparam int DEPTH = 8;
  localparam int W     = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         wr_en = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic         pop = 1'b0;
  logic         pndng;
  logic [W-1:0] D_pop;
  logic         full;
  logic [3:0]   count;
  logic         overflow;
  logic         underflow;
`ifdef BUS_FIFO_DROP_CNT_EN
  logic [15:0]  drop_cnt;
`endif

  bus_port_fifo #(.pckg_sz(W), .depth(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .pop       (pop),
    .pndng     (pndng),
    .D_pop     (D_pop),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
`ifdef BUS_FIFO_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: packet queue plus flags.
  logic [W-1:0] q[$];
  logic         m_ovf = 1'b0;
  logic         m_udf = 1'b0;
  int           m_drop = 0;

  typedef struct {
    logic         rst;
    logic         we;
    logic [W-1:0] wd;
    logic         p;
    int           e_cnt;
    logic         e_pndng;
    logic [W-1:0] e_dpop;
    logic         e_full;
    logic         e_ovf;
    logic         e_udf;
  } vec_t;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic rst, input logic we, input logic [W-1:0] wd, input logic p);
    int sz;
    if (rst) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_drop = 0;
    end else begin
      sz = q.size();
      if (we && sz == DEPTH && !p) begin
        m_ovf = 1'b1;
        if (m_drop < 65535) m_drop++;
      end
      if (p && sz == 0) m_udf = 1'b1;
      if (p && sz > 0) void'(q.pop_front());
      if (we && (sz < DEPTH || p)) q.push_back(wd);
    end
  endtask

  task automatic check_model(input string tag);
    logic [W-1:0] head;
    head = (q.size() > 0) ? q[0] : '0;
    cmp({tag, ".count"}, 32'(count), 32'(q.size()));
    cmp({tag, ".pndng"}, 32'(pndng), 32'(q.size() != 0));
    cmp({tag, ".D_pop"}, 32'(D_pop), 32'(head));
    cmp({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
    cmp({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    cmp({tag, ".underflow"}, 32'(underflow), 32'(m_udf));
`ifdef BUS_FIFO_DROP_CNT_EN
    cmp({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(m_drop));
`endif
  endtask

  // Drive one cycle of inputs, clock it, advance the model and compare.
  task automatic cycle(input string tag, input logic rst, input logic we,
                       input logic [W-1:0] wd, input logic p);
    reset = rst; wr_en = we; wr_data = wd; pop = p;
    @(posedge clk);
    #1;
    model_step(rst, we, wd, p);
    reset = 1'b0; wr_en = 1'b0; pop = 1'b0;
    check_model(tag);
  endtask

  vec_t vt[$];

  initial begin
    logic [W-1:0] exp_seq[$];
    // Directed table: expected outputs after each clock edge.
    vt.push_back('{1, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0});
    vt.push_back('{0, 1, 16'hA001, 0, 1, 1, 16'hA001, 0, 0, 0});
    vt.push_back('{0, 1, 16'hA002, 0, 2, 1, 16'hA001, 0, 0, 0});
    vt.push_back('{0, 1, 16'hA003, 0, 3, 1, 16'hA001, 0, 0, 0});
    vt.push_back('{0, 0, 16'h0000, 1, 2, 1, 16'hA002, 0, 0, 0});
    vt.push_back('{0, 0, 16'h0000, 1, 1, 1, 16'hA003, 0, 0, 0});
    vt.push_back('{0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 0});
    vt.push_back('{0, 1, 16'h1234, 1, 1, 1, 16'h1234, 0, 0, 1});
    vt.push_back('{0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 1});
    vt.push_back('{1, 1, 16'h5555, 1, 0, 0, 16'h0000, 0, 0, 0});

    @(negedge clk);
    foreach (vt[i]) begin
      cycle($sformatf("vec%0d", i), vt[i].rst, vt[i].we, vt[i].wd, vt[i].p);
      cmp($sformatf("vec%0d.count_tbl", i), 32'(count), 32'(vt[i].e_cnt));
      cmp($sformatf("vec%0d.pndng_tbl", i), 32'(pndng), 32'(vt[i].e_pndng));
      cmp($sformatf("vec%0d.dpop_tbl", i), 32'(D_pop), 32'(vt[i].e_dpop));
      cmp($sformatf("vec%0d.full_tbl", i), 32'(full), 32'(vt[i].e_full));
      cmp($sformatf("vec%0d.ovf_tbl", i), 32'(overflow), 32'(vt[i].e_ovf));
      cmp($sformatf("vec%0d.udf_tbl", i), 32'(underflow), 32'(vt[i].e_udf));
    end

    // Fill, overflow with DEAD, then full write+pop with BEEF, then drain.
    for (int i = 0; i < DEPTH; i++) cycle("fill", 0, 1, W'(i), 0);
    cycle("ovf", 0, 1, 16'hDEAD, 0);
    cmp("ovf.full", 32'(full), 32'd1);
    cmp("ovf.count", 32'(count), 32'd8);
    cmp("ovf.flag", 32'(overflow), 32'd1);
`ifdef BUS_FIFO_DROP_CNT_EN
    cmp("ovf.drop_cnt", 32'(drop_cnt), 32'd1);
`endif
    cycle("fullwp", 0, 1, 16'hBEEF, 1);
    cmp("fullwp.count", 32'(count), 32'd8);
    cmp("fullwp.head", 32'(D_pop), 32'h0001);
    for (int i = 1; i < DEPTH; i++) exp_seq.push_back(W'(i));
    exp_seq.push_back(16'hBEEF);
    foreach (exp_seq[i]) begin
      cmp($sformatf("drain%0d", i), 32'(D_pop), 32'(exp_seq[i]));
      cycle("drain", 0, 0, 16'h0, 1);
    end
    cmp("drain.empty", 32'(pndng), 32'd0);

    // Streaming: pop every cycle after the first write; pointers wrap twice.
    cycle("srst", 1, 0, 16'h0, 0);
    for (int i = 0; i < 20; i++) begin
      if (i > 0) cmp($sformatf("stream%0d.head", i), 32'(D_pop), 32'(16'hC000 + i - 1));
      cycle("stream", 0, 1, W'(16'hC000 + i), i > 0);
      cmp("stream.count_le1", 32'(count <= 4'd1), 32'd1);
    end
    cmp("stream.last", 32'(D_pop), 32'hC013);
    cycle("stream_end", 0, 0, 16'h0, 1);

    // Reset mid-burst with a concurrent write.
    for (int i = 0; i < 5; i++) cycle("load5", 0, 1, W'(16'hE000 + i), 0);
    cycle("rstw", 1, 1, 16'h5555, 0);
    cmp("rstw.count", 32'(count), 32'd0);
    cmp("rstw.dpop", 32'(D_pop), 32'd0);
    cycle("post", 0, 1, 16'h7777, 0);
    cmp("post.head", 32'(D_pop), 32'h7777);
    cycle("post2", 0, 0, 16'h0, 1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cycle("rand", $urandom_range(0, 99) == 0, $urandom_range(0, 99) < 55,
            W'($urandom), $urandom_range(0, 99) < 45);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
